// File: rtl/item_cfg_mem.sv
// Item configuration table: a 32-bit word per item plus a valid bitmap, with a
// config read/write port and a three-state vend transaction that decrements stock.
module item_cfg_mem #(
  parameter int unsigned MAX_ITEMS  = 1024,
  parameter int unsigned ADDR_WIDTH = $clog2(MAX_ITEMS)
) (
  input  logic                  clk_fsm,
  input  logic                  rst,
  input  logic                  cfg_read_en,
  input  logic [ADDR_WIDTH-1:0] cfg_read_addr,
  output logic [31:0]           cfg_read_data,
  output logic                  cfg_read_valid,
  input  logic                  cfg_write_en,
  input  logic [ADDR_WIDTH-1:0] cfg_write_addr,
  input  logic [31:0]           cfg_write_data,
  input  logic                  vend_req,
  input  logic [ADDR_WIDTH-1:0] vend_addr,
  output logic                  vend_busy,
  output logic                  vend_done,
  output logic                  vend_ok,
  output logic [15:0]           vend_price,
  output logic [7:0]            vend_stock,
  output logic                  vend_conflict
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic [31:0]           mem [MAX_ITEMS];
  logic [MAX_ITEMS-1:0]  valid_q;

  logic [1:0]            state_q;
  logic [ADDR_WIDTH-1:0] vaddr_q;
  logic [31:0]           ent_q;
  logic                  ent_valid_q;
  logic                  conflict_q;
  logic                  vend_req_q;

  logic [31:0]           rd_data_q;
  logic                  rd_valid_q;
  logic                  done_q;
  logic                  ok_q;
  logic [15:0]           price_q;
  logic [7:0]            stock_q;
  logic                  conflict_out_q;

  logic                  hit;
  logic                  conflict_now;
  logic [7:0]            ent_stock;
  logic [15:0]           ent_price;
  logic                  wb_ok;
  logic                  wb_en;
  logic [31:0]           wb_word;

  always_comb begin
    hit          = cfg_write_en && (cfg_write_addr == vaddr_q);
    conflict_now = conflict_q || hit;
    ent_stock    = ent_q[23:16];
    ent_price    = ent_q[15:0];
    wb_ok        = ent_valid_q && (ent_stock != 8'd0) && !conflict_now;
    wb_en        = (state_q == ST_WB) && wb_ok && !rst;
    wb_word      = {ent_q[31:24], ent_stock - 8'd1, ent_price};
  end

  // Word storage is deliberately not reset; only the valid bitmap is.
  // A vend write-back never collides with a config write: that case is a conflict.
  always_ff @(posedge clk_fsm) begin
    if (!rst && cfg_write_en) begin
      mem[cfg_write_addr] <= cfg_write_data;
    end
    if (wb_en) begin
      mem[vaddr_q] <= wb_word;
    end
  end

  always_ff @(posedge clk_fsm) begin
    if (rst) begin
      valid_q        <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      state_q        <= ST_IDLE;
      vaddr_q        <= '0;
      ent_q          <= '0;
      ent_valid_q    <= 1'b0;
      conflict_q     <= 1'b0;
      vend_req_q     <= 1'b0;
      done_q         <= 1'b0;
      ok_q           <= 1'b0;
      price_q        <= '0;
      stock_q        <= '0;
      conflict_out_q <= 1'b0;
    end else begin
      vend_req_q     <= vend_req;
      rd_valid_q     <= cfg_read_en;
      done_q         <= 1'b0;
      ok_q           <= 1'b0;
      conflict_out_q <= 1'b0;
      if (cfg_read_en) begin
        rd_data_q <= valid_q[cfg_read_addr] ? mem[cfg_read_addr] : 32'd0;
      end
      if (cfg_write_en) begin
        valid_q[cfg_write_addr] <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          // Edge-triggered so a held request starts only one vend.
          if (vend_req && !vend_req_q) begin
            vaddr_q    <= vend_addr;
            conflict_q <= 1'b0;
            state_q    <= ST_RD;
          end
        end
        ST_RD: begin
          ent_q       <= mem[vaddr_q];
          ent_valid_q <= valid_q[vaddr_q];
          conflict_q  <= hit;
          state_q     <= ST_WB;
        end
        ST_WB: begin
          done_q         <= 1'b1;
          ok_q           <= wb_ok;
          conflict_out_q <= conflict_now;
          price_q        <= ent_valid_q ? ent_price : 16'd0;
          if (!ent_valid_q) begin
            stock_q <= 8'd0;
          end else if (wb_ok) begin
            stock_q <= ent_stock - 8'd1;
          end else begin
            stock_q <= ent_stock;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_read_data  = rd_data_q;
    cfg_read_valid = rd_valid_q;
    vend_busy      = (state_q != ST_IDLE);
    vend_done      = done_q;
    vend_ok        = ok_q;
    vend_price     = price_q;
    vend_stock     = stock_q;
    vend_conflict  = conflict_out_q;
  end

endmodule

// File: tb/tb_item_cfg_mem.sv
// Directed bench for item_cfg_mem: table-driven config port vectors plus
// hand-written vend, conflict, held-request and reset-abort sequences.
module tb_item_cfg_mem;

  localparam int AW = 10;

  logic          clk_fsm = 1'b0;
  logic          rst;
  logic          cfg_read_en;
  logic [AW-1:0] cfg_read_addr;
  logic [31:0]   cfg_read_data;
  logic          cfg_read_valid;
  logic          cfg_write_en;
  logic [AW-1:0] cfg_write_addr;
  logic [31:0]   cfg_write_data;
  logic          vend_req;
  logic [AW-1:0] vend_addr;
  logic          vend_busy;
  logic          vend_done;
  logic          vend_ok;
  logic [15:0]   vend_price;
  logic [7:0]    vend_stock;
  logic          vend_conflict;

  int total = 0;
  int bad   = 0;

  item_cfg_mem dut (
    .clk_fsm        (clk_fsm),
    .rst            (rst),
    .cfg_read_en    (cfg_read_en),
    .cfg_read_addr  (cfg_read_addr),
    .cfg_read_data  (cfg_read_data),
    .cfg_read_valid (cfg_read_valid),
    .cfg_write_en   (cfg_write_en),
    .cfg_write_addr (cfg_write_addr),
    .cfg_write_data (cfg_write_data),
    .vend_req       (vend_req),
    .vend_addr      (vend_addr),
    .vend_busy      (vend_busy),
    .vend_done      (vend_done),
    .vend_ok        (vend_ok),
    .vend_price     (vend_price),
    .vend_stock     (vend_stock),
    .vend_conflict  (vend_conflict)
  );

  always #5 clk_fsm = ~clk_fsm;

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          re;
    logic [AW-1:0] raddr;
    logic          exp_valid;
    logic [31:0]   exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk_fsm);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [31:0] d);
    cfg_write_en   = 1'b1;
    cfg_write_addr = a;
    cfg_write_data = d;
    step();
    cfg_write_en = 1'b0;
  endtask

  task automatic cfg_read_chk(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    cfg_read_en   = 1'b1;
    cfg_read_addr = a;
    step();
    cfg_read_en = 1'b0;
    chk({name, "_valid"}, {31'd0, cfg_read_valid}, 32'd1);
    chk(name, cfg_read_data, exp);
  endtask

  task automatic do_vend(input string name, input logic [AW-1:0] a, input logic exp_ok,
                         input logic [15:0] exp_price, input logic [7:0] exp_stock);
    vend_req  = 1'b1;
    vend_addr = a;
    step();
    vend_req = 1'b0;
    chk({name, "_busy_rd"}, {31'd0, vend_busy}, 32'd1);
    chk({name, "_done_rd"}, {31'd0, vend_done}, 32'd0);
    step();
    chk({name, "_busy_wb"}, {31'd0, vend_busy}, 32'd1);
    chk({name, "_done_wb"}, {31'd0, vend_done}, 32'd0);
    step();
    chk({name, "_done"}, {31'd0, vend_done}, 32'd1);
    chk({name, "_ok"}, {31'd0, vend_ok}, {31'd0, exp_ok});
    chk({name, "_price"}, {16'd0, vend_price}, {16'd0, exp_price});
    chk({name, "_stock"}, {24'd0, vend_stock}, {24'd0, exp_stock});
    chk({name, "_conflict"}, {31'd0, vend_conflict}, 32'd0);
    chk({name, "_busy_end"}, {31'd0, vend_busy}, 32'd0);
    step();
    chk({name, "_done_pulse"}, {31'd0, vend_done}, 32'd0);
    chk({name, "_stock_hold"}, {24'd0, vend_stock}, {24'd0, exp_stock});
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    cfg_read_en = 1'b0;
    cfg_read_addr = '0;
    cfg_write_en = 1'b0;
    cfg_write_addr = '0;
    cfg_write_data = '0;
    vend_req = 1'b0;
    vend_addr = '0;

    //           we    waddr   wdata          re    raddr   valid exp
    vecs[0] = '{1'b1, 10'd5, 32'h0003_00C8, 1'b0, 10'd0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 10'd0, 32'h0,         1'b1, 10'd5, 1'b1, 32'h0003_00C8};
    vecs[2] = '{1'b0, 10'd0, 32'h0,         1'b1, 10'd6, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 10'd7, 32'h11,        1'b0, 10'd0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 10'd7, 32'h22,        1'b1, 10'd7, 1'b1, 32'h11};
    vecs[5] = '{1'b0, 10'd0, 32'h0,         1'b1, 10'd7, 1'b1, 32'h22};
    vecs[6] = '{1'b0, 10'd0, 32'h0,         1'b0, 10'd0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 10'd8, 32'hDEAD_BEEF, 1'b1, 10'd8, 1'b1, 32'h0};
    vecs[8] = '{1'b0, 10'd0, 32'h0,         1'b1, 10'd8, 1'b1, 32'hDEAD_BEEF};

    step();
    step();
    chk("rst_busy", {31'd0, vend_busy}, 32'd0);
    chk("rst_done", {31'd0, vend_done}, 32'd0);
    chk("rst_rvalid", {31'd0, cfg_read_valid}, 32'd0);
    chk("rst_rdata", cfg_read_data, 32'd0);
    chk("rst_stock", {24'd0, vend_stock}, 32'd0);
    chk("rst_price", {16'd0, vend_price}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      cfg_write_en   = vecs[i].we;
      cfg_write_addr = vecs[i].waddr;
      cfg_write_data = vecs[i].wdata;
      cfg_read_en    = vecs[i].re;
      cfg_read_addr  = vecs[i].raddr;
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, cfg_read_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), cfg_read_data, vecs[i].exp_data);
    end
    cfg_write_en = 1'b0;
    cfg_read_en  = 1'b0;
    step();
    chk("rdata_hold", cfg_read_data, 32'hDEAD_BEEF);

    // Stock 3 drains to 0, then the next vend must fail without wrapping.
    do_vend("v1", 10'd5, 1'b1, 16'd200, 8'd2);
    do_vend("v2", 10'd5, 1'b1, 16'd200, 8'd1);
    do_vend("v3", 10'd5, 1'b1, 16'd200, 8'd0);
    do_vend("v4", 10'd5, 1'b0, 16'd200, 8'd0);
    cfg_read_chk("after_v4", 10'd5, 32'h0000_00C8);
    do_vend("v_invalid", 10'd6, 1'b0, 16'd0, 8'd0);

    // Config write to another index during a vend leaves the vend intact.
    cfg_write(10'd5, 32'h0003_00C8);
    vend_req = 1'b1;
    vend_addr = 10'd5;
    step();
    vend_req = 1'b0;
    cfg_write(10'd9, 32'h0000_0001);
    step();
    chk("other_done", {31'd0, vend_done}, 32'd1);
    chk("other_ok", {31'd0, vend_ok}, 32'd1);
    chk("other_conflict", {31'd0, vend_conflict}, 32'd0);
    chk("other_stock", {24'd0, vend_stock}, 32'd2);

    // Conflict: config write to the vend index in the RD cycle.
    cfg_write(10'd5, 32'h0003_00C8);
    vend_req = 1'b1;
    vend_addr = 10'd5;
    step();
    vend_req = 1'b0;
    cfg_write(10'd5, 32'h0009_0064);
    step();
    chk("conf_done", {31'd0, vend_done}, 32'd1);
    chk("conf_ok", {31'd0, vend_ok}, 32'd0);
    chk("conf_flag", {31'd0, vend_conflict}, 32'd1);
    step();
    chk("conf_pulse", {31'd0, vend_conflict}, 32'd0);
    cfg_read_chk("conf_rb", 10'd5, 32'h0009_0064);

    // Conflict in the WB cycle also suppresses write-back.
    vend_req = 1'b1;
    step();
    vend_req = 1'b0;
    step();
    cfg_write(10'd5, 32'h0009_0064);
    chk("confwb_done", {31'd0, vend_done}, 32'd1);
    chk("confwb_flag", {31'd0, vend_conflict}, 32'd1);
    cfg_read_chk("confwb_rb", 10'd5, 32'h0009_0064);

    // Held request yields a single vend.
    dones = 0;
    vend_req = 1'b1;
    vend_addr = 10'd5;
    for (int i = 0; i < 5; i++) begin
      step();
      if (vend_done) dones++;
    end
    vend_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (vend_done) dones++;
    end
    chk("held_dones", dones, 32'd1);
    cfg_read_chk("held_rb", 10'd5, 32'h0008_0064);

    // Reset in the WB cycle aborts the vend.
    vend_req = 1'b1;
    step();
    vend_req = 1'b0;
    step();
    chk("rstwb_in_wb", {31'd0, vend_busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstwb_done", {31'd0, vend_done}, 32'd0);
    chk("rstwb_busy", {31'd0, vend_busy}, 32'd0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (vend_done) dones++;
    end
    chk("rstwb_no_done", dones, 32'd0);
    cfg_read_chk("rstwb_rb", 10'd5, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/item_cfg_mem.md
ITEM_CFG_MEM -- requirements
Module: item_cfg_mem

Interface
REQ-001 The block SHALL have parameter MAX_ITEMS, default 1024, meaning the number of item table entries.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default $clog2(MAX_ITEMS), meaning the item index width.
REQ-003 The block SHALL have one clock and a synchronous active-high reset:
- clk_fsm  in  1  FSM-domain clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have the following ports:
- cfg_read_en  in  1  config read strobe.
- cfg_read_addr  in  ADDR_WIDTH  config read index.
- cfg_read_data  out  32  config read data.
- cfg_read_valid  out  1  one-cycle pulse; cfg_read_data valid.
- cfg_write_en  in  1  config write strobe.
- cfg_write_addr  in  ADDR_WIDTH  config write index.
- cfg_write_data  in  32  entry word: [15:0] price, [23:16] stock, [31:24] reserved.
- vend_req  in  1  vend request pulse from the vending FSM.
- vend_addr  in  ADDR_WIDTH  item to vend.
- vend_busy  out  1  vend transaction in progress.
- vend_done  out  1  one-cycle completion pulse.
- vend_ok  out  1  qualified by vend_done; stock decremented.
- vend_price  out  16  qualified by vend_done; item price.
- vend_stock  out  8  qualified by vend_done; stock after the vend.
- vend_conflict  out  1  qualified by vend_done; aborted by a config write.

Function
REQ-005 Storage SHALL be MAX_ITEMS x 32-bit words plus a MAX_ITEMS-bit valid bitmap; the bitmap SHALL clear on reset and the words SHALL NOT be reset.
REQ-006 A cfg_write_en cycle SHALL write cfg_write_data to the word at cfg_write_addr and set its valid bit, both visible from the next cycle.
REQ-007 A cfg_read_en in cycle N SHALL produce cfg_read_valid=1 in cycle N+1, with cfg_read_data set to the stored word, or 0 if the entry is invalid.
REQ-008 cfg_read_data SHALL hold its value until the next read; cfg_read_valid SHALL be 0 in every other cycle.
REQ-009 When cfg_read_en and cfg_write_en hit the same index in one cycle, the read SHALL return the pre-write value.
REQ-010 Config reads SHALL be serviced every cycle regardless of vend state, with no stall.
REQ-011 The vend FSM SHALL have the states IDLE, RD and WB, with vend_busy=1 in RD and WB.
REQ-012 In IDLE, vend_req=1 SHALL latch vend_addr and move to RD; vend_req in RD or WB SHALL be ignored.
REQ-013 RD SHALL capture the entry word and valid bit, then move to WB.
REQ-014 WB SHALL pulse vend_done, then return to IDLE, giving 3 cycles from request to done.
REQ-015 In WB, if the entry is valid and stock>0, the block SHALL write back stock-1 with price unchanged and drive vend_ok=1 and vend_stock=stock-1.
REQ-016 In WB, if the entry is invalid or stock==0, the block SHALL NOT write and SHALL drive vend_ok=0 and vend_stock=stock (0 if invalid).
REQ-017 vend_price SHALL equal the entry price, or 0 if the entry is invalid.
REQ-018 Stock SHALL never wrap below 0.
REQ-019 A cfg_write_en to the latched vend index while in RD or WB SHALL take effect, suppress the vend write-back, and make WB report vend_ok=0 and vend_conflict=1; a config write to any other index SHALL not affect the vend.
REQ-020 vend_conflict SHALL be 0 in every case not covered by REQ-019.
REQ-021 vend_done, vend_ok and vend_conflict SHALL be single-cycle pulses; vend_price and vend_stock SHALL hold until the next vend_done.

Reset
REQ-022 rst=1 SHALL force the FSM to IDLE, clear the valid bitmap, and drive every output to 0 on the next edge.
REQ-023 rst asserted during RD or WB SHALL abort the vend with no write-back and no vend_done.

Verification
REQ-024 Write index 5 = 0x0003_00C8, read index 5 -> cfg_read_valid one cycle later with data 0x0003_00C8; read index 6 (never written) -> 0.
REQ-025 Vend index 5 three times then once more -> vend_done at request+3 each time; vend_stock 2, 1, 0 with vend_ok=1 and vend_price=200; fourth vend -> vend_ok=0, vend_stock=0, memory unchanged.
REQ-026 Vend index 5 (stock 3) with a config write to index 5 = 0x0009_0064 in the RD cycle -> vend_conflict=1, vend_ok=0, read-back 0x0009_0064.
REQ-027 Same-cycle config read and write of index 7 (old 0x11, new 0x22) -> read returns 0x11; next read returns 0x22.
REQ-028 vend_req held high for 5 cycles -> exactly one vend_done, stock decremented once.
REQ-029 rst pulsed in the WB cycle -> no vend_done, stock unchanged, subsequent read of the index returns 0.
